cache_plru_state: RTL and testbench
===================================

Name: cache_plru_state

Overview:
- Per-set pseudo-LRU state store and update engine for the 8-way set-associative cache.
- Holds the 7-bit PLRU tree for every set and updates the tree on each hit or fill.
- Presents the registered tree bits for a looked-up set on `get_lru`. These bits feed the downstream combinational victim selector, which walks the tree to a 3-bit way.
- Provides a sequenced whole-array clear for cache flush.

Parameters:
- `SETS`, 64, number of cache sets (PLRU entries).
- `INDEX`, 6, set index width; must equal log2(`SETS`).
- `WAYS`, 8, associativity; only 8 is supported.
- `WAYS_REP`, 3, way encoding width; only 3 is supported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `access_valid`  in  1  hit/fill to a way; update this cycle.
- `access_set`  in  `INDEX`  set being accessed.
- `access_way`  in  `WAYS_REP`  way being accessed (binary).
- `access_ready`  out  1  high when updates are accepted (IDLE).
- `lookup_valid`  in  1  request PLRU bits for `lookup_set`.
- `lookup_set`  in  `INDEX`  set whose tree is requested.
- `get_lru`  out  `WAYS-1` (7)  registered tree bits for the last accepted lookup.
- `get_lru_valid`  out  1  `get_lru` is valid this cycle.
- `clear_req`  in  1  pulse: start a clear of all entries.
- `busy`  out  1  clear sweep in progress.

Behaviour:
- **Tree encoding** (fixed, shared with the victim selector):
  - Bit 0 is the root: 0 selects ways 0-3, 1 selects ways 4-7.
  - Bit 1 splits ways 0-1 (0) / 2-3 (1). Bit 2 splits ways 4-5 (0) / 6-7 (1).
  - Bits 3, 4, 5, 6 are the leaves for way pairs 0/1, 2/3, 4/5, 6/7; 0 selects the even way.
- **Update on access to way w** (w = w2 w1 w0): set the path bits to point away from w; all other bits are unchanged.
  - Bit 0 = ~w2.
  - If w2 = 0: bit 1 = ~w1 and bit (3+w1) = ~w0.
  - If w2 = 1: bit 2 = ~w1 and bit (5+w1) = ~w0.
- **Reset:**
  - Asynchronously, all entries go to 0, the FSM goes to IDLE, and the internal clear counter goes to 0.
  - Output reset values: `get_lru` = 0, `get_lru_valid` = 0, `busy` = 0, `access_ready` = 0 while `rst` is high.
  - `rst` asserted mid-sweep aborts the sweep immediately.
- **FSM:**
  - IDLE goes to CLEAR on `clear_req`.
  - CLEAR writes entry[count] = 0 each cycle and increments count. CLEAR goes to IDLE after writing `SETS`-1.
  - `busy` = (state == CLEAR), registered. It is high for exactly `SETS` cycles starting the cycle after `clear_req` is sampled.
  - `access_ready` = (state == IDLE) && !`rst`, combinational.
- **Update timing:** an access with `access_valid` && `access_ready` at edge N is written at edge N. It is visible to lookups issued from edge N+1 onward.
- **Lookup timing:** `lookup_valid` sampled at edge N gives `get_lru` / `get_lru_valid` = 1 after edge N. Latency is 1 cycle and one lookup is accepted per cycle. `get_lru_valid` is 0 in cycles with no lookup, and `get_lru` holds its last value.
- **Same-set lookup and access in one cycle:** write-first bypass; `get_lru` returns the updated tree.
- **During CLEAR:** accesses are dropped (`access_ready` = 0). Lookups are ignored (`get_lru_valid` = 0).
- **`clear_req` in IDLE with a simultaneous access:** the access is written, then the sweep clears it. A lookup in that same cycle is served normally.
- **`clear_req` while busy:** ignored; the sweep is not restarted.
- `access_set` and `lookup_set` are always in range; no wrap checks are needed.

Test Plan:
- **Reset default:** deassert `rst`, lookup set 5 -> next cycle `get_lru` = 7'h00, `get_lru_valid` = 1 (victim way 0).
- **Single access:** access set 3 way 0, then lookup set 3 -> `get_lru` = 7'h0B (bits 0, 1, 3); lookup set 4 -> 7'h00.
- **Full rotation:** accesses to set 2 for ways 0,1,...,7 on consecutive cycles, then lookup set 2 -> `get_lru` = 7'h00 (way 0 is true LRU).
- **Bypass:** from reset, access set 7 way 4 and lookup set 7 in the same cycle -> next cycle `get_lru` = 7'h24 (bits 2, 5).
- **Clear:** populate sets 0, 31, 63 with nonzero trees, then pulse `clear_req`.
  - `busy` = 1 for exactly 64 cycles with `access_ready` = 0.
  - An access issued during the sweep has no effect.
  - After the sweep, lookups of sets 0, 31, 63 -> 7'h00.
- **Reset mid-clear:** assert `rst` 10 cycles into the sweep -> `busy` = 0 and `get_lru_valid` = 0 immediately; after release, every set reads 7'h00.

Source files
------------

// File: rtl/cache_plru_state.sv
// cache_plru_state: per-set 7-bit PLRU tree store with hit/fill update, registered lookup and sequenced flush.
// Ports:
//   clk, rst                                 clock, async active-high reset
//   access_valid/access_set/access_way       hit/fill update request; access_ready high when accepted (IDLE)
//   lookup_valid/lookup_set                  tree read request; get_lru/get_lru_valid one cycle later
//   clear_req                                start whole-array clear; busy high while the sweep runs
module cache_plru_state #(
  parameter int SETS     = 64,
  parameter int INDEX    = 6,
  parameter int WAYS     = 8,
  parameter int WAYS_REP = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                access_valid,
  input  logic [INDEX-1:0]    access_set,
  input  logic [WAYS_REP-1:0] access_way,
  output logic                access_ready,
  input  logic                lookup_valid,
  input  logic [INDEX-1:0]    lookup_set,
  output logic [WAYS-2:0]     get_lru,
  output logic                get_lru_valid,
  input  logic                clear_req,
  output logic                busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t             r_state, w_state_nxt;
  logic [WAYS-2:0]    r_tree [SETS];
  logic [INDEX-1:0]   r_cnt;
  logic [WAYS-2:0]    r_get_lru;
  logic               r_get_lru_valid;
  logic               w_idle, w_wr, w_rd;
  logic [WAYS-2:0]    w_old, w_upd;
  assign w_idle        = (r_state == IDLE);
  assign access_ready  = w_idle && !rst;
  assign busy          = (r_state == CLEAR);
  assign w_wr          = access_valid && w_idle;
  assign w_rd          = lookup_valid && w_idle;
  assign w_old         = r_tree[access_set];
  assign get_lru       = r_get_lru;
  assign get_lru_valid = r_get_lru_valid;
  // point every node on the accessed way's path away from it
  always_comb begin
    w_upd    = w_old;
    w_upd[0] = ~access_way[2];
    if (access_way[2]) begin
      w_upd[2] = ~access_way[1];
      w_upd[access_way[1] ? 6 : 5] = ~access_way[0];
    end else begin
      w_upd[1] = ~access_way[1];
      w_upd[access_way[1] ? 4 : 3] = ~access_way[0];
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    if (w_idle && clear_req) w_state_nxt = CLEAR;
    else if (busy && r_cnt == INDEX'(SETS - 1)) w_state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= busy ? r_cnt + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) r_tree[i] <= '0;
    end else if (busy) begin
      r_tree[r_cnt] <= '0;
    end else if (w_wr) begin
      r_tree[access_set] <= w_upd;
    end
  end
  // same-set access and lookup in one cycle returns the freshly updated tree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_get_lru       <= '0;
      r_get_lru_valid <= 1'b0;
    end else begin
      r_get_lru_valid <= w_rd;
      if (w_rd) r_get_lru <= (w_wr && lookup_set == access_set) ? w_upd : r_tree[lookup_set];
    end
  end
endmodule

// File: tb/tb_cache_plru_state.sv
// tb_cache_plru_state: randomized and directed checks of cache_plru_state against a tree-walk reference model.
module tb_cache_plru_state;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       access_valid = 1'b0;
  logic [5:0] access_set = '0;
  logic [2:0] access_way = '0;
  logic       access_ready;
  logic       lookup_valid = 1'b0;
  logic [5:0] lookup_set = '0;
  logic [6:0] get_lru;
  logic       get_lru_valid;
  logic       clear_req = 1'b0;
  logic       busy;
  int         vectors = 0;
  int         errors = 0;
  logic [6:0] m_tree [64];
  logic [6:0] m_lru = '0;
  logic       m_lv = 1'b0;
  logic       m_busy = 1'b0;
  int         m_pos = 0;
  int         busy_len;
  always #5 clk = ~clk;
  cache_plru_state dut (
    .clk(clk), .rst(rst),
    .access_valid(access_valid), .access_set(access_set), .access_way(access_way),
    .access_ready(access_ready),
    .lookup_valid(lookup_valid), .lookup_set(lookup_set),
    .get_lru(get_lru), .get_lru_valid(get_lru_valid),
    .clear_req(clear_req), .busy(busy)
  );
  // walk the binary tree as a heap (children of node n are 2n+1, 2n+2) and point each visited node away
  function automatic logic [6:0] m_upd(logic [6:0] t, int w);
    logic [6:0] r = t;
    int n = 0;
    for (int l = 0; l < 3; l++) begin
      int d = (w >> (2 - l)) & 1;
      r[n] = (d == 0);
      n = 2 * n + 1 + d;
    end
    return r;
  endfunction
  task automatic chk(string tag, logic [6:0] got, logic [6:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic acc(int s, int w);
    access_valid = 1'b1;
    access_set = 6'(s);
    access_way = 3'(w);
  endtask
  task automatic look(int s);
    lookup_valid = 1'b1;
    lookup_set = 6'(s);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tree[i] = '0;
    m_lru = '0;
    m_lv = 1'b0;
    m_busy = 1'b0;
    m_pos = 0;
  endtask
  task automatic cycle();
    logic rdy = !m_busy;
    if (lookup_valid && rdy) begin
      m_lru = (access_valid && access_set == lookup_set) ? m_upd(m_tree[access_set], int'(access_way)) : m_tree[lookup_set];
      m_lv = 1'b1;
    end else m_lv = 1'b0;
    if (access_valid && rdy) m_tree[access_set] = m_upd(m_tree[access_set], int'(access_way));
    if (m_busy) begin
      m_tree[m_pos] = '0;
      m_pos++;
      if (m_pos == 64) m_busy = 1'b0;
    end else if (clear_req) begin
      m_busy = 1'b1;
      m_pos = 0;
    end
    @(posedge clk);
    #1;
    chk("get_lru_valid", 7'(get_lru_valid), 7'(m_lv));
    chk("get_lru", get_lru, m_lru);
    chk("busy", 7'(busy), 7'(m_busy));
    chk("access_ready", 7'(access_ready), 7'(!m_busy));
    access_valid = 1'b0;
    lookup_valid = 1'b0;
    clear_req = 1'b0;
  endtask
  initial begin
    model_reset();
    #12;
    chk("rst_get_lru", get_lru, 7'h00);
    chk("rst_valid", 7'(get_lru_valid), 7'h0);
    chk("rst_busy", 7'(busy), 7'h0);
    chk("rst_ready", 7'(access_ready), 7'h0);
    @(negedge clk);
    rst = 1'b0;
    look(5); cycle();
    chk("reset_default", get_lru, 7'h00);
    access_set = 0;
    acc(3, 0); cycle();
    look(3); cycle();
    chk("single_set3", get_lru, 7'h0B);
    look(4); cycle();
    chk("single_set4", get_lru, 7'h00);
    for (int w = 0; w < 8; w++) begin acc(2, w); cycle(); end
    look(2); cycle();
    chk("full_rotation", get_lru, 7'h00);
    acc(7, 4); look(7); cycle();
    chk("bypass", get_lru, 7'h24);
    cycle();
    chk("idle_valid_low", 7'(get_lru_valid), 7'h0);
    chk("idle_lru_hold", get_lru, 7'h24);
    acc(0, 5); cycle();
    acc(31, 2); cycle();
    acc(63, 7); cycle();
    look(63); cycle();
    chk("populate63", get_lru, m_upd(7'h00, 7));
    clear_req = 1'b1; acc(31, 6); look(0); cycle();
    chk("clear_lookup_served", 7'(get_lru_valid), 7'h1);
    busy_len = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      busy_len++;
      if (i == 5) acc(31, 1);
      if (i == 7) look(31);
      if (i == 9) clear_req = 1'b1;
      cycle();
    end
    chk("busy_len", 7'(busy_len), 7'd64);
    look(0); cycle(); chk("clr_set0", get_lru, 7'h00);
    look(31); cycle(); chk("clr_set31", get_lru, 7'h00);
    look(63); cycle(); chk("clr_set63", get_lru, 7'h00);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) acc($urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) look($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) clear_req = 1'b1;
      cycle();
    end
    while (m_busy) cycle();
    for (int s = 0; s < 4; s++) begin acc(s, $urandom_range(0, 7)); cycle(); end
    clear_req = 1'b1; cycle();
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b1;
    #1;
    model_reset();
    chk("midclr_busy", 7'(busy), 7'h0);
    chk("midclr_valid", 7'(get_lru_valid), 7'h0);
    chk("midclr_ready", 7'(access_ready), 7'h0);
    chk("midclr_lru", get_lru, 7'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 64; s++) begin look(s); cycle(); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
